// File: rtl/gate_bist_pkg.sv
// Shared definitions for the gate BIST sequencer: modes, states, reference.
package gate_bist_pkg;

  localparam logic [2:0] MODE_NOR  = 3'd0;
  localparam logic [2:0] MODE_NAND = 3'd1;
  localparam logic [2:0] MODE_AND  = 3'd2;
  localparam logic [2:0] MODE_OR   = 3'd3;
  localparam logic [2:0] MODE_XOR  = 3'd4;
  localparam logic [2:0] MODE_XNOR = 3'd5;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_APPLY = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // mask selects the live gate inputs; unused bits act as 0 for OR/XOR, 1 for AND
  function automatic logic ref_gate(
    input logic [2:0] mode,
    input logic [7:0] vec,
    input logic [7:0] mask
  );
    logic any_v;
    logic all_v;
    logic par_v;
    any_v = |(vec & mask);
    all_v = &(vec | ~mask);
    par_v = ^(vec & mask);
    case (mode)
      MODE_NOR:  ref_gate = ~any_v;
      MODE_NAND: ref_gate = ~all_v;
      MODE_AND:  ref_gate = all_v;
      MODE_OR:   ref_gate = any_v;
      MODE_XOR:  ref_gate = par_v;
      MODE_XNOR: ref_gate = ~par_v;
      default:   ref_gate = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gate_bist_sequencer_ref.sv
// Combinational reference gate: expected output for a vector under a mode.
module gate_ref_model
  import gate_bist_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [2:0]   mode,
  input  logic [N-1:0] vec,
  output logic         ref_out
);

  logic [7:0] mask;

  assign mask    = ~(8'hFF << N);
  assign ref_out = ref_gate(mode, 8'(vec), mask);

endmodule

// File: rtl/gate_bist_sequencer.sv
// Exhaustive self-test sequencer for an N-input gate primitive.
module gate_bist_sequencer
  import gate_bist_pkg::*;
#(
  parameter int N      = 2,
  parameter int SETTLE = 1,
  parameter int ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  output logic [N-1:0]     dut_in,
  input  logic             dut_out,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [N-1:0]     first_fail_vec,
  output logic             first_fail_valid
);

  // with no settle window a vector goes straight to its check cycle
  localparam logic [1:0] ST_RUN =
    (SETTLE == 0) ? ST_CHECK : ST_APPLY;
  localparam logic [3:0] SETTLE_LAST =
    4'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [N:0] VEC_LAST =
    (N+1)'((1 << N) - 1);

  logic [1:0] state;
  logic [2:0] mode_q;
  logic [N:0] vec;
  logic [3:0] settle_cnt;
  logic       ref_out;
  logic       mismatch;

  gate_ref_model #(.N(N)) u_ref (
    .mode    (mode_q),
    .vec     (vec[N-1:0]),
    .ref_out (ref_out)
  );

  assign dut_in   = vec[N-1:0];
  assign busy     = (state == ST_APPLY) || (state == ST_CHECK);
  assign done     = (state == ST_DONE);
  assign mismatch = (state == ST_CHECK) && (dut_out != ref_out);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= ST_IDLE;
      mode_q           <= MODE_NOR;
      vec              <= '0;
      settle_cnt       <= '0;
      err_count        <= '0;
      first_fail_vec   <= '0;
      first_fail_valid <= 1'b0;
      pass             <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            err_count        <= '0;
            first_fail_valid <= 1'b0;
            pass             <= 1'b0;
            if (mode <= MODE_XNOR) begin
              mode_q     <= mode;
              vec        <= '0;
              settle_cnt <= '0;
              state      <= ST_RUN;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_APPLY: begin
          if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= ST_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count != '1)
              err_count <= err_count + 1'b1;
            if (!first_fail_valid) begin
              first_fail_vec   <= vec[N-1:0];
              first_fail_valid <= 1'b1;
            end
          end
          if (vec == VEC_LAST) begin
            pass  <= !(first_fail_valid || mismatch);
            state <= ST_DONE;
          end else begin
            vec   <= vec + 1'b1;
            state <= ST_RUN;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gate_bist_sequencer.sv
// Scoreboard bench for gate_bist_sequencer: N=2/SETTLE=1 and N=3/SETTLE=0/ERR_W=2.
module tb_gate_bist_sequencer;

  typedef struct {
    int lat;
    int pass;
    int err;
    int ffv;
    int ffok;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start_a = 1'b0, start_b = 1'b0;
  logic [2:0] mode_a = 3'd0, mode_b = 3'd0;
  logic [1:0] in_a;
  logic [2:0] in_b;
  logic       out_a, out_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [7:0] err_a;
  logic [1:0] err_b;
  logic [1:0] ffv_a;
  logic [2:0] ffv_b;
  logic       ffok_a, ffok_b;

  int sel = 0;
  int kind = 0;
  int gmode = 0;

  gate_bist_sequencer #(.N(2), .SETTLE(1), .ERR_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .mode(mode_a),
    .dut_in(in_a), .dut_out(out_a), .busy(busy_a), .done(done_a),
    .pass(pass_a), .err_count(err_a), .first_fail_vec(ffv_a),
    .first_fail_valid(ffok_a)
  );

  gate_bist_sequencer #(.N(3), .SETTLE(0), .ERR_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .mode(mode_b),
    .dut_in(in_b), .dut_out(out_b), .busy(busy_b), .done(done_b),
    .pass(pass_b), .err_count(err_b), .first_fail_vec(ffv_b),
    .first_fail_valid(ffok_b)
  );

  function automatic bit tb_ref(int m, int n, int v);
    int ones = 0;
    for (int i = 0; i < n; i++) ones += (v >> i) & 1;
    case (m)
      0: return ones == 0;
      1: return ones != n;
      2: return ones == n;
      3: return ones > 0;
      4: return (ones % 2) == 1;
      5: return (ones % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  // kind 0: healthy gate, 1: stuck-at-0, 2: XNOR gate
  function automatic bit gate_model(int k, int m, int n, int v);
    if (k == 1) return 1'b0;
    if (k == 2) return tb_ref(5, n, v);
    return tb_ref(m, n, v);
  endfunction

  always_comb out_a = gate_model(kind, gmode, 2, int'(in_a));
  always_comb out_b = gate_model(kind, gmode, 3, int'(in_b));

  int o_vec, o_err, o_ffv;
  logic o_busy, o_done, o_pass, o_ffok;
  always_comb begin
    o_vec  = (sel != 0) ? int'(in_b)  : int'(in_a);
    o_err  = (sel != 0) ? int'(err_b) : int'(err_a);
    o_ffv  = (sel != 0) ? int'(ffv_b) : int'(ffv_a);
    o_busy = (sel != 0) ? busy_b : busy_a;
    o_done = (sel != 0) ? done_b : done_a;
    o_pass = (sel != 0) ? pass_b : pass_a;
    o_ffok = (sel != 0) ? ffok_b : ffok_a;
  end

  task automatic check(input string tag, input int got, input int want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  task automatic drive(input int s, input bit st, input int m);
    if (s != 0) begin
      start_b = st;
      mode_b  = 3'(m);
    end else begin
      start_a = st;
      mode_a  = 3'(m);
    end
  endtask

  task automatic run(input int s, input int m, input int k, input bit repulse);
    int n  = (s != 0) ? 3 : 2;
    int st = (s != 0) ? 0 : 1;
    int ew = (s != 0) ? 2 : 8;
    int nv = 1 << n;
    int cyc;
    exp_t e;
    sel = s;
    kind = k;
    gmode = m;
    e.err = 0;
    e.ffv = 0;
    e.ffok = 0;
    if (m > 5) begin
      e.lat = 1;
    end else begin
      e.lat = nv * (st + 1) + 1;
      for (int v = 0; v < nv; v++) begin
        if (gate_model(k, m, n, v) != tb_ref(m, n, v)) begin
          if (e.err < (1 << ew) - 1) e.err++;
          if (e.ffok == 0) begin
            e.ffv = v;
            e.ffok = 1;
          end
        end
      end
    end
    e.pass = (m <= 5 && e.err == 0) ? 1 : 0;
    sb.push_back(e);
    @(negedge clk);
    drive(s, 1'b1, m);
    @(negedge clk);
    drive(s, 1'b0, m);
    cyc = 1;
    while (!o_done && cyc < 200) begin
      if (cyc <= nv * (st + 1))
        check("dut_in_step", o_vec, (cyc - 1) / (st + 1));
      check("busy_run", int'(o_busy), 1);
      if (repulse && cyc == 3) drive(s, 1'b1, 1);
      if (repulse && cyc == 4) drive(s, 1'b0, 1);
      @(negedge clk);
      cyc++;
    end
    drive(s, 1'b0, m);
    e = sb.pop_front();
    check("done_latency", cyc, e.lat);
    check("done_high", int'(o_done), 1);
    check("busy_at_done", int'(o_busy), 0);
    check("pass", int'(o_pass), e.pass);
    check("err_count", o_err, e.err);
    if (m <= 5) check("ff_valid", int'(o_ffok), e.ffok);
    if (e.ffok != 0) check("ff_vec", o_ffv, e.ffv);
    @(negedge clk);
    check("done_pulse_end", int'(o_done), 0);
    check("pass_hold", int'(o_pass), e.pass);
    if (m <= 5) check("dut_in_hold", o_vec, nv - 1);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_dut_in_a", int'(in_a), 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_done_a", int'(done_a), 0);
    check("rst_pass_a", int'(pass_a), 0);
    check("rst_err_a", int'(err_a), 0);
    check("rst_ffv_a", int'(ffv_a), 0);
    check("rst_ffok_a", int'(ffok_a), 0);
    check("rst_dut_in_b", int'(in_b), 0);
    check("rst_err_b", int'(err_b), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run(0, 0, 0, 1'b0);
    run(0, 0, 1, 1'b0);
    run(1, 2, 1, 1'b0);
    run(1, 4, 2, 1'b0);
    run(0, 6, 0, 1'b0);
    run(0, 0, 0, 1'b1);
    run(0, 3, 1, 1'b0);

    // abort mid-run after a failing run left state behind
    sel = 0;
    kind = 0;
    gmode = 0;
    @(negedge clk);
    drive(0, 1'b1, 0);
    @(negedge clk);
    drive(0, 1'b0, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_dut_in", int'(in_a), 0);
    check("abort_busy", int'(busy_a), 0);
    check("abort_done", int'(done_a), 0);
    check("abort_pass", int'(pass_a), 0);
    check("abort_err", int'(err_a), 0);
    check("abort_ffv", int'(ffv_a), 0);
    check("abort_ffok", int'(ffok_a), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", int'(done_a), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run(0, 1, 0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
